// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding / hazard controller.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package fwd_pkg;

   // Select value meaning "take the operand from the register file"
   localparam int FWD_NONE = 0;

   // Width of one forward select: encodes 0 (register file) plus one code per stage
   function automatic int sel_w(input int num_fwd);
      int w;
      w = $clog2(num_fwd + 1);
      if (w < 1) w = 1;
      return w;
   endfunction

   typedef enum logic {
      MC_IDLE = 1'b0,
      MC_BUSY = 1'b1
   } mc_state_t;

endpackage

// File: rtl/fwd_hazard_ctrl_mc_scoreboard.sv
// Scoreboard for the single multi-cycle unit: launch, countdown, done pulse, dependency match.
// Latency: result returns MC_LAT cycles after acceptance; mc_accept is combinational.
// Backpressure: mc_start is only accepted when idle or in the done cycle; otherwise it must be held.
module mc_scoreboard
   import fwd_pkg::*;
#(
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 2,
   parameter int MC_LAT  = 4
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mc_start,
   input  logic [REG_AW-1:0]         mc_wreg,
   input  logic [NUM_SRC*REG_AW-1:0] src_id,
   output logic                      mc_accept,
   output logic                      mc_busy,
   output logic                      mc_done,
   output logic                      mc_dep
);

   localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(MC_LAT - 1);

   mc_state_t         state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [REG_AW-1:0] reg_q, reg_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              src_hit;

   // A new op may launch when idle, or in the done cycle for back-to-back use
   assign mc_accept = !rst && mc_start && ((state_q == MC_IDLE) || done_q);
   assign mc_busy   = busy_q;
   assign mc_done   = done_q;

   // Does any ID source read the register the in-flight op will write
   always_comb begin
      src_hit = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
         if (src_id[s*REG_AW +: REG_AW] == reg_q) src_hit = 1'b1;
      end
   end

   // Dependent reads wait until the result is on the forwarding path (done cycle)
   assign mc_dep = busy_q && !done_q && (reg_q != '0) && src_hit;

   // Next state: launch loads the countdown, BUSY counts down to the done cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      reg_d   = reg_q;
      if (mc_accept) begin
         state_d = MC_BUSY;
         cnt_d   = CNT_INIT;
         reg_d   = mc_wreg;
      end else if (state_q == MC_BUSY) begin
         if (cnt_q == '0) begin
            state_d = MC_IDLE;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
      busy_d = (state_d == MC_BUSY);
      done_d = (state_d == MC_BUSY) && (cnt_d == '0);
   end

   // FSM registers; reset abandons any op in flight without a done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MC_IDLE;
         cnt_q   <= '0;
         reg_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         reg_q   <= reg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Operand forwarding selects, load-use and multi-cycle hazard stalls; optional perf counters (FWD_PERF_CNT_EN).
// Latency: fwd_sel/stall_id/flush_ex combinational; counters update one edge after the qualifying cycle.
// Backpressure: stall_id holds PC and IF/ID; flush_ex bubbles ID/EX; held mc_start stalls until accepted.
module fwd_hazard_ctrl
   import fwd_pkg::*;
#(
   parameter  int REG_AW  = 5,
   parameter  int NUM_SRC = 2,
   parameter  int NUM_FWD = 2,
   parameter  int MC_LAT  = 4,
   parameter  int CNT_W   = 16,
   localparam int SEL_W   = sel_w(NUM_FWD)
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC*REG_AW-1:0] src_ex,
   input  logic [NUM_SRC*REG_AW-1:0] src_id,
   input  logic [NUM_FWD*REG_AW-1:0] fwd_wreg,
   input  logic [NUM_FWD-1:0]        fwd_wen,
   input  logic                      ex_memread,
   input  logic                      ex_regwrite,
   input  logic [REG_AW-1:0]         ex_wreg,
   input  logic                      mc_start,
   input  logic [REG_AW-1:0]         mc_wreg,
   output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
   output logic                      stall_id,
   output logic                      flush_ex,
   output logic                      mc_accept,
   output logic                      mc_busy,
   output logic                      mc_done,
   output logic [CNT_W-1:0]          stall_cnt,
   output logic [CNT_W-1:0]          fwd_cnt
);

   logic load_use;
   logic lu_hit;
   logic mc_dep;
   logic mc_struct;

   // Forward select per source: scan farthest to nearest so the nearest stage overwrites
   always_comb begin
      fwd_sel = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_wen[k] && (fwd_wreg[k*REG_AW +: REG_AW] != '0) &&
                (fwd_wreg[k*REG_AW +: REG_AW] == src_ex[s*REG_AW +: REG_AW])) begin
               fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(k + 1);
            end
         end
      end
   end

   // Load in EX whose destination is read by the instruction in ID
   always_comb begin
      lu_hit = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
         if (src_id[s*REG_AW +: REG_AW] == ex_wreg) lu_hit = 1'b1;
      end
   end

   assign load_use = ex_memread && ex_regwrite && (ex_wreg != '0) && lu_hit;

   mc_scoreboard #(
      .REG_AW  (REG_AW),
      .NUM_SRC (NUM_SRC),
      .MC_LAT  (MC_LAT)
   ) u_mc_sb (
      .clk       (clk),
      .rst       (rst),
      .mc_start  (mc_start),
      .mc_wreg   (mc_wreg),
      .src_id    (src_id),
      .mc_accept (mc_accept),
      .mc_busy   (mc_busy),
      .mc_done   (mc_done),
      .mc_dep    (mc_dep)
   );

   // A launch request refused because the unit is occupied holds ID without a bubble
   assign mc_struct = mc_start && !mc_accept;

   assign stall_id = !rst && (load_use || mc_dep || mc_struct);
   assign flush_ex = !rst && (load_use || mc_dep);

`ifdef FWD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
   logic             any_fwd;

   assign any_fwd = |fwd_sel;

   // Saturating event counts; they stick at all-ones rather than wrap
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      fwd_cnt_d   = fwd_cnt_q;
      if (stall_id && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (any_fwd && (fwd_cnt_q != '1))    fwd_cnt_d   = fwd_cnt_q + 1'b1;
   end

   // Counter registers, cleared by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign fwd_cnt   = fwd_cnt_q;
`else
   assign stall_cnt = '0;
   assign fwd_cnt   = '0;
`endif

endmodule
